// File: rtl/hazard_ctrl_if.sv
// Hazard-control bundle between the RV32I pipeline (master) and hazard_ctrl (slave).
// Carries hazard detection inputs and the stage enable/flush/fault outputs.
interface hazard_ctrl_if;
  logic       mem_read_ID_EX;
  logic [4:0] rd_ID_EX;
  logic [4:0] rs1_IF_ID;
  logic [4:0] rs2_IF_ID;
  logic       uses_rs1_IF_ID;
  logic       uses_rs2_IF_ID;
  logic       branch_taken_EX;
  logic       dmem_req_EX_MEM;
  logic       dmem_ready;

  logic       pc_en;
  logic       if_id_en;
  logic       id_ex_en;
  logic       ex_mem_en;
  logic       mem_wb_en;
  logic       if_id_flush;
  logic       id_ex_flush;
  logic       mem_wb_flush;
  logic       mem_fault;

  modport master (
    output mem_read_ID_EX, rd_ID_EX, rs1_IF_ID, rs2_IF_ID, uses_rs1_IF_ID, uses_rs2_IF_ID,
           branch_taken_EX, dmem_req_EX_MEM, dmem_ready,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush,
           mem_wb_flush, mem_fault
  );

  modport slave (
    input  mem_read_ID_EX, rd_ID_EX, rs1_IF_ID, rs2_IF_ID, uses_rs1_IF_ID, uses_rs2_IF_ID,
           branch_taken_EX, dmem_req_EX_MEM, dmem_ready,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush,
           mem_wb_flush, mem_fault
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: reset hold, load-use stall, branch flush, dmem wait/timeout.
// Define HAZARD_PERF_CNT_EN to build the stall/flush/load-use performance counters.
module hazard_ctrl #(
  parameter int unsigned RESET_HOLD  = 2,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave hz,
  output logic [31:0]  stall_cycles,
  output logic [31:0]  flush_events,
  output logic [31:0]  load_use_events
);

  localparam int unsigned HoldW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam int unsigned WaitW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(RESET_HOLD - 1);
  localparam logic [WaitW-1:0] WaitMax  = WaitW'(MEM_TIMEOUT);
  localparam logic [WaitW-1:0] WaitLast = (MEM_TIMEOUT > 0) ? WaitW'(MEM_TIMEOUT - 1) : '0;

  localparam logic [1:0] StInit    = 2'd0;
  localparam logic [1:0] StRun     = 2'd1;
  localparam logic [1:0] StMemWait = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [WaitW-1:0] wait_q, wait_d;

  logic lu, ms, timeout, freeze, init_out;

  always_comb begin
    lu = hz.mem_read_ID_EX && (hz.rd_ID_EX != 5'd0) &&
         ((hz.uses_rs1_IF_ID && (hz.rs1_IF_ID == hz.rd_ID_EX)) ||
          (hz.uses_rs2_IF_ID && (hz.rs2_IF_ID == hz.rd_ID_EX)));
    ms       = hz.dmem_req_EX_MEM && !hz.dmem_ready;
    timeout  = (MEM_TIMEOUT != 0) && ms && (wait_q == WaitLast);
    freeze   = ms && !timeout;
    init_out = rst || (state_q == StInit);
  end

  always_comb begin
    hz.pc_en        = 1'b1;
    hz.if_id_en     = 1'b1;
    hz.id_ex_en     = 1'b1;
    hz.ex_mem_en    = 1'b1;
    hz.mem_wb_en    = 1'b1;
    hz.if_id_flush  = 1'b0;
    hz.id_ex_flush  = 1'b0;
    hz.mem_wb_flush = 1'b0;
    hz.mem_fault    = 1'b0;
    if (init_out) begin
      hz.pc_en        = 1'b0;
      hz.if_id_flush  = 1'b1;
      hz.id_ex_flush  = 1'b1;
      hz.mem_wb_flush = 1'b1;
    end else if (freeze) begin
      hz.pc_en     = 1'b0;
      hz.if_id_en  = 1'b0;
      hz.id_ex_en  = 1'b0;
      hz.ex_mem_en = 1'b0;
      hz.mem_wb_en = 1'b0;
    end else begin
      // A timed-out access is dropped and the whole pipe is released.
      hz.mem_fault    = timeout;
      hz.mem_wb_flush = timeout;
      if (hz.branch_taken_EX) begin
        hz.if_id_flush = 1'b1;
        hz.id_ex_flush = 1'b1;
      end else if (lu) begin
        hz.id_ex_flush = 1'b1;
        if (!timeout) begin
          hz.pc_en    = 1'b0;
          hz.if_id_en = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    wait_d  = wait_q;
    case (state_q)
      StInit: begin
        if (hold_q == HoldLast) begin
          state_d = StRun;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      StRun, StMemWait: begin
        if (freeze) begin
          state_d = StMemWait;
          if (wait_q != WaitMax) wait_d = wait_q + 1'b1;
        end else begin
          state_d = StRun;
          wait_d  = '0;
        end
      end
      default: begin
        state_d = StInit;
        hold_d  = '0;
        wait_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StInit;
      hold_q  <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      wait_q  <= wait_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles    <= '0;
      flush_events    <= '0;
      load_use_events <= '0;
    end else if (state_q != StInit) begin
      if (!hz.pc_en) stall_cycles <= stall_cycles + 32'd1;
      if (hz.branch_taken_EX && !freeze) flush_events <= flush_events + 32'd1;
      if (lu && !hz.branch_taken_EX && !freeze) load_use_events <= load_use_events + 32'd1;
    end
  end
`else
  assign stall_cycles    = 32'd0;
  assign flush_events    = 32'd0;
  assign load_use_events = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a rule-level reference model checked every cycle.
module tb_hazard_ctrl;
  localparam int unsigned RH = 2;
  localparam int unsigned MT = 4;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PerfOn = 1'b1;
`else
  localparam bit PerfOn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] stall_cycles, flush_events, load_use_events;
  hazard_ctrl_if hz ();

  hazard_ctrl #(.RESET_HOLD(RH), .MEM_TIMEOUT(MT)) dut (
    .clk             (clk),
    .rst             (rst),
    .hz              (hz),
    .stall_cycles    (stall_cycles),
    .flush_events    (flush_events),
    .load_use_events (load_use_events)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  wire [4:0] en_v = {hz.pc_en, hz.if_id_en, hz.id_ex_en, hz.ex_mem_en, hz.mem_wb_en};
  wire [2:0] fl_v = {hz.if_id_flush, hz.id_ex_flush, hz.mem_wb_flush};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  int          hold_left = RH;
  int          ms_run = 0;
  logic [31:0] m_stall = 0, m_flush = 0, m_lu = 0;

  always @(negedge clk) begin
    bit lu_m, ms_m, br_m, tout_m, frz_m, in_init;
    logic [4:0] e_en;
    logic [2:0] e_fl;
    logic       e_fault;
    lu_m = hz.mem_read_ID_EX && hz.rd_ID_EX != 0 &&
           ((hz.uses_rs1_IF_ID && hz.rs1_IF_ID == hz.rd_ID_EX) ||
            (hz.uses_rs2_IF_ID && hz.rs2_IF_ID == hz.rd_ID_EX));
    ms_m    = hz.dmem_req_EX_MEM && !hz.dmem_ready;
    br_m    = hz.branch_taken_EX;
    tout_m  = (MT > 0) && ms_m && (ms_run + 1 == int'(MT));
    frz_m   = ms_m && !tout_m;
    in_init = rst || hold_left > 0;
    e_fault = 1'b0;
    if (in_init) begin
      e_en = 5'b01111; e_fl = 3'b111;
    end else if (frz_m) begin
      e_en = 5'b00000; e_fl = 3'b000;
    end else begin
      e_en = 5'b11111; e_fl = 3'b000;
      if (tout_m) begin e_fault = 1'b1; e_fl[0] = 1'b1; end
      if (br_m) e_fl[2:1] = 2'b11;
      else if (lu_m) begin
        e_fl[1] = 1'b1;
        if (!tout_m) e_en[4:3] = 2'b00;
      end
    end
    chk("model_enables", {27'd0, en_v}, {27'd0, e_en});
    chk("model_flushes", {29'd0, fl_v}, {29'd0, e_fl});
    chk("model_fault", {31'd0, hz.mem_fault}, {31'd0, e_fault});
    chk("model_stall_cnt", stall_cycles, m_stall);
    chk("model_flush_cnt", flush_events, m_flush);
    chk("model_lu_cnt", load_use_events, m_lu);
    if (rst) begin
      hold_left = RH; ms_run = 0; m_stall = 0; m_flush = 0; m_lu = 0;
    end else if (hold_left > 0) begin
      hold_left--;
    end else begin
      ms_run = frz_m ? ms_run + 1 : 0;
      if (PerfOn) begin
        if (!e_en[4]) m_stall++;
        if (br_m && !frz_m) m_flush++;
        if (lu_m && !br_m && !frz_m) m_lu++;
      end
    end
  end

  task automatic set_in(input bit mr, input bit [4:0] rd, input bit [4:0] r1, input bit [4:0] r2,
                        input bit u1, input bit u2, input bit br, input bit req, input bit rdy);
    hz.mem_read_ID_EX  = mr;
    hz.rd_ID_EX        = rd;
    hz.rs1_IF_ID       = r1;
    hz.rs2_IF_ID       = r2;
    hz.uses_rs1_IF_ID  = u1;
    hz.uses_rs2_IF_ID  = u2;
    hz.branch_taken_EX = br;
    hz.dmem_req_EX_MEM = req;
    hz.dmem_ready      = rdy;
  endtask

  task automatic settle;
    @(negedge clk); #1;
  endtask

  task automatic next;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      settle;
      chk("rst_pc_en", {31'd0, hz.pc_en}, 32'd0);
      chk("rst_flushes", {29'd0, fl_v}, 32'd7);
      next;
    end
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle;
      chk("init_pc_en", {31'd0, hz.pc_en}, 32'd0);
      chk("init_flushes", {29'd0, fl_v}, 32'd7);
      next;
    end
    settle;
    chk("run_pc_en", {31'd0, hz.pc_en}, 32'd1);
    chk("run_flushes", {29'd0, fl_v}, 32'd0);
    next;

    // lw x5 in EX, ID reads rs2 = x5
    set_in(1, 5, 0, 5, 0, 1, 0, 0, 1);
    settle;
    chk("lu_enables", {27'd0, en_v}, 32'b00111);
    chk("lu_id_ex_flush", {31'd0, hz.id_ex_flush}, 32'd1);
    next;
    set_in(0, 0, 0, 5, 0, 1, 0, 0, 1);
    settle;
    chk("post_lu_enables", {27'd0, en_v}, 32'b11111);
    chk("post_lu_flushes", {29'd0, fl_v}, 32'd0);
    next;
    set_in(1, 0, 0, 0, 0, 1, 0, 0, 1);
    settle;
    chk("lu_rd0_pc_en", {31'd0, hz.pc_en}, 32'd1);
    next;
    set_in(1, 7, 7, 3, 0, 1, 0, 0, 1);
    settle;
    chk("lu_rs1_unused", {31'd0, hz.pc_en}, 32'd1);
    next;
    set_in(1, 7, 7, 3, 1, 0, 0, 0, 1);
    settle;
    chk("lu_rs1_used", {31'd0, hz.pc_en}, 32'd0);
    next;

    // Branch in the same cycle as a load-use
    set_in(1, 5, 0, 5, 0, 1, 1, 0, 1);
    settle;
    chk("br_lu_enables", {27'd0, en_v}, 32'b11111);
    chk("br_lu_flushes", {29'd0, fl_v}, 32'b110);
    next;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
    next;

    // Memory wait with a branch held across it
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 1, 1, 0);
      settle;
      chk("wait_enables", {27'd0, en_v}, 32'd0);
      chk("wait_flushes", {29'd0, fl_v}, 32'd0);
      next;
    end
    set_in(0, 0, 0, 0, 0, 0, 1, 1, 1);
    settle;
    chk("release_enables", {27'd0, en_v}, 32'b11111);
    chk("release_flushes", {29'd0, fl_v}, 32'b110);
    chk("release_fault", {31'd0, hz.mem_fault}, 32'd0);
    next;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
    settle;
    chk("back_in_run", {27'd0, en_v}, 32'b11111);
    next;

    // Timeout after MT consecutive not-ready cycles
    for (int c = 1; c <= 5; c++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
      settle;
      if (c < 4) begin
        chk("to_stall_enables", {27'd0, en_v}, 32'd0);
        chk("to_stall_fault", {31'd0, hz.mem_fault}, 32'd0);
      end else if (c == 4) begin
        chk("to_fault", {31'd0, hz.mem_fault}, 32'd1);
        chk("to_mem_wb_flush", {31'd0, hz.mem_wb_flush}, 32'd1);
        chk("to_enables", {27'd0, en_v}, 32'b11111);
      end else begin
        chk("to_after_fault", {31'd0, hz.mem_fault}, 32'd0);
        chk("to_after_enables", {27'd0, en_v}, 32'd0);
      end
      next;
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
    next;

    // Reset arriving at wait count 2
    for (int i = 0; i < 2; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
      next;
    end
    rst = 1'b1;
    settle;
    chk("rst_wait_fault", {31'd0, hz.mem_fault}, 32'd0);
    chk("rst_wait_flushes", {29'd0, fl_v}, 32'd7);
    next;
    rst = 1'b0;
    settle;
    chk("rst_wait_init_pc", {31'd0, hz.pc_en}, 32'd0);
    chk("rst_wait_init_fault", {31'd0, hz.mem_fault}, 32'd0);
    chk("rst_wait_init_flush", {29'd0, fl_v}, 32'd7);
    chk("perf_stall_zero", stall_cycles, 32'd0);
    chk("perf_flush_zero", flush_events, 32'd0);
    chk("perf_lu_zero", load_use_events, 32'd0);
    next;
    for (int i = 0; i < 6; i++) next;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
    next;
    next;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
